// File: rtl/fifo_pop_arbiter.sv
// Purpose: pops one of four FIFOs per cycle (almost_full first, then round-robin) into a 3-entry ordered output buffer.
// Latency: pop in cycle t, read data captured at the end of t+1, presented on valid_out in cycle t+2.
// Backpressure: dest_ready low holds the head entry stable; pops stop once buffered + inflight words reach 3.
//
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   enable            permits new pops (dropping it while busy drains the buffer)
//   empty[3:0]        per-FIFO empty flags (lag a pop by 2 cycles)
//   almost_full[3:0]  per-FIFO priority request
//   fifo_err[3:0]     per-FIFO error flags, folded into the sticky err output
//   q0..q3[3:0]       FIFO read data, valid the cycle after that FIFO's pop
//   pop[3:0]          one-hot-or-zero pop strobes
//   dest_ready        downstream accept
//   valid_out         head entry valid
//   data_out[3:0]     head entry payload
//   src_id[1:0]       head entry source FIFO index
//   err               sticky error (fifo_err seen or buffer overflow)
//   busy              state machine is not IDLE
module fifo_pop_arbiter (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic [3:0] empty,
    input  logic [3:0] almost_full,
    input  logic [3:0] fifo_err,
    input  logic [3:0] q0,
    input  logic [3:0] q1,
    input  logic [3:0] q2,
    input  logic [3:0] q3,
    output logic [3:0] pop,
    input  logic       dest_ready,
    output logic       valid_out,
    output logic [3:0] data_out,
    output logic [1:0] src_id,
    output logic       err,
    output logic       busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t     r_state;
    state_t     w_state_nxt;

    logic [1:0] r_cool [4];
    logic [1:0] r_last_grant;
    logic       r_inflight;
    logic [1:0] r_inf_src;
    logic [5:0] r_buf [3];
    logic [1:0] r_rd_ptr;
    logic [1:0] r_wr_ptr;
    logic [1:0] r_occ;
    logic       r_err;

    logic [2:0] w_load;
    logic [3:0] w_elig;
    logic [3:0] w_cand;
    logic [3:0] w_pop;
    logic       w_pop_any;
    logic [1:0] w_grant;
    logic [1:0] w_idx;
    logic [3:0] w_cap_data;
    logic       w_valid;
    logic       w_deq;
    logic       w_wr;
    logic       w_overflow;

    function automatic logic [1:0] ptr_inc(input logic [1:0] p);
        return (p == 2'd2) ? 2'd0 : p + 2'd1;
    endfunction

    // Words already committed to the buffer: stored plus the one arriving next edge.
    assign w_load = {1'b0, r_occ} + {2'b00, r_inflight};

    always_comb begin
        w_elig = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            w_elig[i] = !empty[i] && (r_cool[i] == 2'd0) && enable
                        && (w_load < 3'd3) && (r_state != DRAIN) && !reset;
        end
    end

    // Priority group first, then round-robin search starting after the last grant.
    always_comb begin
        w_cand    = (|(w_elig & almost_full)) ? (w_elig & almost_full) : w_elig;
        w_grant   = r_last_grant;
        w_pop_any = 1'b0;
        w_idx     = 2'd0;
        for (int k = 1; k <= 4; k++) begin
            w_idx = r_last_grant + 2'(k);
            if (!w_pop_any && w_cand[w_idx]) begin
                w_grant   = w_idx;
                w_pop_any = 1'b1;
            end
        end
        w_pop = w_pop_any ? (4'b0001 << w_grant) : 4'b0000;
    end

    always_comb begin
        w_cap_data = q0;
        case (r_inf_src)
            2'd0:    w_cap_data = q0;
            2'd1:    w_cap_data = q1;
            2'd2:    w_cap_data = q2;
            default: w_cap_data = q3;
        endcase
    end

    assign w_valid    = (r_occ != 2'd0);
    assign w_deq      = w_valid && dest_ready;
    // A capture into a full buffer is only safe if the head leaves in the same cycle.
    assign w_wr       = r_inflight && ((r_occ != 2'd3) || w_deq);
    assign w_overflow = r_inflight && (r_occ == 2'd3) && !w_deq;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_last_grant <= 2'd3;
            r_inflight   <= 1'b0;
            r_inf_src    <= 2'd0;
            r_rd_ptr     <= 2'd0;
            r_wr_ptr     <= 2'd0;
            r_occ        <= 2'd0;
            r_err        <= 1'b0;
            for (int i = 0; i < 4; i++) r_cool[i] <= 2'd0;
            for (int i = 0; i < 3; i++) r_buf[i] <= 6'd0;
        end else begin
            if (w_wr) begin
                r_buf[r_wr_ptr] <= {r_inf_src, w_cap_data};
                r_wr_ptr        <= ptr_inc(r_wr_ptr);
            end
            if (w_deq) r_rd_ptr <= ptr_inc(r_rd_ptr);
            case ({w_wr, w_deq})
                2'b10:   r_occ <= r_occ + 2'd1;
                2'b01:   r_occ <= r_occ - 2'd1;
                default: r_occ <= r_occ;
            endcase

            r_inflight <= w_pop_any;
            r_inf_src  <= w_grant;
            if (w_pop_any) r_last_grant <= w_grant;

            // Empty lags pop by 2 cycles, so a popped FIFO sits out the next two.
            for (int i = 0; i < 4; i++) begin
                if (w_pop[i])                r_cool[i] <= 2'd2;
                else if (r_cool[i] != 2'd0)  r_cool[i] <= r_cool[i] - 2'd1;
            end

            if ((|fifo_err) || w_overflow) r_err <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (w_pop_any) w_state_nxt = RUN;
            end
            RUN: begin
                if (!enable)
                    w_state_nxt = DRAIN;
                else if ((w_elig == 4'b0000) && (r_occ == 2'd0) && !r_inflight)
                    w_state_nxt = IDLE;
            end
            DRAIN: begin
                if (enable)
                    w_state_nxt = RUN;
                else if ((r_occ == 2'd0) && !r_inflight)
                    w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Outputs are forced to their idle values for the whole time reset is high,
    // including the first cycle before the registers have been cleared.
    assign pop       = w_pop;
    assign valid_out = w_valid && !reset;
    assign data_out  = valid_out ? r_buf[r_rd_ptr][3:0] : 4'd0;
    assign src_id    = valid_out ? r_buf[r_rd_ptr][5:4] : 2'd0;
    assign err       = r_err && !reset;
    assign busy      = (r_state != IDLE) && !reset;

endmodule

// File: doc/fifo_pop_arbiter.md
FIFO_POP_ARBITER -- requirements
Module: fifo_pop_arbiter

Interface
REQ-001 SHALL have ports, clock and reset first: clk in 1 clock; reset in 1 synchronous active-high reset; enable in 1 permit new pops; empty in 4 per-FIFO empty flag, bit i = FIFO i; almost_full in 4 per-FIFO almost_full flag; fifo_err in 4 per-FIFO error flag; q0, q1, q2, q3 in 4 each FIFO read data, valid the cycle after its pop; pop out 4 one-hot-or-zero pop strobes; dest_ready in 1 downstream accept; valid_out out 1 output data valid; data_out out 4 payload; src_id out 2 index of the source FIFO; err out 1 sticky error; busy out 1 state is not IDLE.
REQ-002 SHALL use reset = reset, synchronous, active-high, and clock = clk; all state updates on posedge clk.

Function
REQ-003 SHALL assert at most one pop bit per cycle, and only for a FIFO that is eligible.
REQ-004 Eligible FIFO i: empty[i]=0 AND cooldown[i]=0 AND enable=1 AND (occ + inflight) < 3.
REQ-005 Cooldown: after pop[i] in cycle t, FIFO i SHALL be ineligible in cycles t+1 and t+2, because empty lags pop by 2 cycles.
REQ-006 Arbitration: eligible FIFOs with almost_full=1 SHALL win over those without; within the winning group, round-robin starting at (last_grant+1) mod 4.
REQ-007 last_grant SHALL update only on a pop, with a reset value of 3, so the first search starts at FIFO 0.
REQ-008 inflight SHALL be 1 in the cycle after a pop, else 0; the captured data is the q of the popped FIFO, tagged with its index.
REQ-009 SHALL keep a 3-entry output buffer (occ 0..3) holding {src_id, data}, in order.
REQ-010 Capture of inflight data and dequeue in the same cycle SHALL leave occ unchanged.
REQ-011 The REQ-004 rule SHALL guarantee the buffer never overflows; a capture while occ=3 with no dequeue SHALL set err.
REQ-012 valid_out = (occ != 0); data_out/src_id = head entry; a transfer occurs when valid_out & dest_ready.
REQ-013 While valid_out=1 and dest_ready=0, data_out and src_id SHALL be held stable.
REQ-014 err SHALL set when any fifo_err bit is 1 or on overflow (REQ-011), and SHALL stay set until reset.
REQ-015 State machine IDLE/RUN/DRAIN, 2-bit.
- IDLE -> RUN when a pop is issued.
- RUN -> DRAIN when enable=0.
- RUN -> IDLE when no FIFO is eligible and occ=0 and inflight=0.
- DRAIN -> IDLE when occ=0 and inflight=0.
- DRAIN -> RUN when enable=1.
REQ-016 In DRAIN, no pops SHALL issue; buffered and inflight data SHALL still be delivered.
REQ-017 Throughput: with 3 or more FIFOs non-empty and dest_ready=1, one pop per cycle sustained; with one non-empty FIFO, one pop per 3 cycles.
REQ-018 Latency: pop in cycle t gives valid_out in cycle t+2 (data captured at the t+1 edge).
REQ-019 fifo_err SHALL NOT block popping; only err is affected.

Reset
REQ-020 While reset=1: pop=0, valid_out=0, data_out=0, src_id=0, err=0, busy=0, occ=0, inflight=0, cooldown=0, last_grant=3, state IDLE.
REQ-021 Reset mid-operation SHALL discard buffered and inflight data with no partial output; the first eligible cycle after deassertion MAY pop.

Verification
REQ-022 FIFO0 holds 3 words A,B,C; others empty; dest_ready=1 -> pops in cycles t, t+3, t+6; outputs A,B,C with src_id=0; never two pops within 2 cycles.
REQ-023 All 4 FIFOs non-empty, no almost_full, dest_ready=1 -> pop order 0,1,2,3,0,... one per cycle; src_id follows the same order.
REQ-024 FIFOs 0 and 2 eligible, almost_full=0100 -> FIFO2 is granted first regardless of round-robin pointer.
REQ-025 All FIFOs full, dest_ready=0 for 10 cycles -> exactly 3 pops, occ=3, data_out held stable, err stays 0; on dest_ready=1, in-order delivery resumes.
REQ-026 enable dropped with occ=2 and one pop inflight -> no further pops, 3 words delivered, state DRAIN -> IDLE, busy falls.
REQ-027 fifo_err[1] pulsed for 1 cycle, then reset mid-stream -> err=1 until reset; after reset all outputs at REQ-020 values.
